// File: rtl/mano_int_enc.sv
// mano_int_enc: eight-line interrupt request encoder for the MANO computer.
//
// Request strobes are captured into a pending register and gated by a
// per-source mask. The lowest-index eligible source is presented to the
// control unit as a 3-bit vector. The vector is held through an ack /
// end-of-interrupt handshake. IEN is owned by the control sequencer and
// only qualifies new presentations here.
//
// Parameters:
//   EDGE_MODE  1: a request sets pending on a sampled 0->1 transition.
//              0: a request sets pending on every cycle it is high.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   asynchronous active-high reset
//   req      in   [7:0] request lines; bit 0 has the highest priority
//   mask_ld  in   load strobe for the mask register
//   mask_in  in   [7:0] new mask value; 1 enables the source
//   ien      in   global interrupt enable
//   ack      in   control unit accepts the presented vector
//   eoi      in   end of interrupt service
//   irq      out  a vector is being presented (registered)
//   vec      out  [2:0] presented / in-service source index (registered)
//   busy     out  a source is in service (registered)
//   pend     out  [7:0] pending register

module mano_int_enc #(
  parameter int unsigned EDGE_MODE = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       mask_ld,
  input  logic [7:0] mask_in,
  input  logic       ien,
  input  logic       ack,
  input  logic       eoi,
  output logic       irq,
  output logic [2:0] vec,
  output logic       busy,
  output logic [7:0] pend
);

  typedef enum logic [1:0] {
    StIdle,
    StPresent,
    StService
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] req_q;
  logic [7:0] pend_q, pend_d;
  logic [7:0] mask_q, mask_d;
  logic [2:0] vec_q, vec_d;
  logic       irq_q, irq_d;
  logic       busy_q, busy_d;

  logic [7:0] set_v;   // pending set conditions this cycle
  logic [7:0] clr_v;   // pending clear from an accepted ack
  logic [7:0] elig;
  logic [2:0] enc;

  // Pending set detection. req_q resets to zero, so a request held high
  // through reset looks like a rising edge on the first clock afterwards.
  always_comb begin
    if (EDGE_MODE != 0) begin
      set_v = req & ~req_q;
    end else begin
      set_v = req;
    end
  end

  // Eligibility uses only registered pend and mask, so a new mask value
  // takes effect one cycle after it is loaded.
  assign elig = pend_q & mask_q;

  // Lowest index wins: scan from the top so the last hit is the smallest.
  always_comb begin
    enc = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (elig[i]) begin
        enc = 3'(i);
      end
    end
  end

  // Handshake FSM next-state and registered-output next values.
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    irq_d   = irq_q;
    busy_d  = busy_q;
    clr_v   = 8'h00;
    unique case (state_q)
      StIdle: begin
        if (ien && (elig != 8'h00)) begin
          state_d = StPresent;
          vec_d   = enc;
          irq_d   = 1'b1;
        end
      end
      StPresent: begin
        // vec stays frozen here; ack outranks a simultaneous ien drop.
        if (ack) begin
          state_d      = StService;
          irq_d        = 1'b0;
          busy_d       = 1'b1;
          clr_v[vec_q] = 1'b1;
        end else if (!ien) begin
          state_d = StIdle;
          irq_d   = 1'b0;
        end
      end
      StService: begin
        // No nesting: nothing is presented until eoi returns us to idle.
        if (eoi) begin
          state_d = StIdle;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
        irq_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // A set condition in the same cycle as the ack clear keeps the bit high.
  assign pend_d = (pend_q & ~clr_v) | set_v;
  assign mask_d = mask_ld ? mask_in : mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= 8'h00;
      pend_q  <= 8'h00;
      mask_q  <= 8'hFF;
      vec_q   <= 3'd0;
      irq_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      vec_q   <= vec_d;
      irq_q   <= irq_d;
      busy_q  <= busy_d;
    end
  end

  assign irq  = irq_q;
  assign vec  = vec_q;
  assign busy = busy_q;
  assign pend = pend_q;

endmodule
